// File: rtl/prime_sweep_ctrl.sv
// prime_sweep_ctrl: steps candidates 2..NumMax through a shared prime-check core and publishes each verdict plus a running prime count.
// Latency: CoreReq rises the cycle after Start. Each candidate takes ISSUE + WAIT + RECORD (3 cycles) plus the core latency.
// Backpressure: CoreReq/CoreNum are held until CoreAck. Optional macro PRIME_SWEEP_TIMEOUT_EN limits each core transaction to TIMEOUT cycles and raises Error.
module prime_sweep_ctrl #(
  parameter int NUM_W   = 10,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 2048
) (
  input  logic             SysClk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [NUM_W-1:0] NumMax,
  output logic             CoreReq,
  output logic [NUM_W-1:0] CoreNum,
  input  logic             CoreAck,
  input  logic             CoreDone,
  input  logic             CoreIsPrime,
  output logic             Prime,
  output logic [NUM_W-1:0] NumberChecked,
  output logic [CNT_W-1:0] NumberofPrimesFound,
  output logic             ResultValid,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RECORD,
    S_DONE
  } state_t;

  state_t           state;
  logic [NUM_W-1:0] cand_q;
  logic [NUM_W-1:0] max_q;
  logic             verdict_q;

`ifdef PRIME_SWEEP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Budget is spent once the counter has covered TIMEOUT cycles in ISSUE/WAIT.
  assign tmo_hit = (tmo_cnt >= TMO_W'(TIMEOUT - 1));
`else
  assign Error = 1'b0;
`endif

  // Sweep sequencer; every output is a register written here.
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      state               <= S_IDLE;
      cand_q              <= '0;
      max_q               <= '0;
      verdict_q           <= 1'b0;
      CoreReq             <= 1'b0;
      CoreNum             <= '0;
      Prime               <= 1'b0;
      NumberChecked       <= '0;
      NumberofPrimesFound <= '0;
      ResultValid         <= 1'b0;
      Busy                <= 1'b0;
      Done                <= 1'b0;
`ifdef PRIME_SWEEP_TIMEOUT_EN
      Error               <= 1'b0;
      tmo_cnt             <= '0;
`endif
    end else begin
      ResultValid <= 1'b0;
`ifdef PRIME_SWEEP_TIMEOUT_EN
      if (state == S_ISSUE || state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
`endif
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            max_q               <= NumMax;
            NumberofPrimesFound <= '0;
            NumberChecked       <= '0;
            Prime               <= 1'b0;
`ifdef PRIME_SWEEP_TIMEOUT_EN
            Error               <= 1'b0;
`endif
            if (NumMax < NUM_W'(2)) begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= S_DONE;
            end else begin
              cand_q  <= NUM_W'(2);
              CoreNum <= NUM_W'(2);
              CoreReq <= 1'b1;
              Busy    <= 1'b1;
              Done    <= 1'b0;
              state   <= S_ISSUE;
`ifdef PRIME_SWEEP_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
        end

        S_ISSUE: begin
          // A verdict that arrives together with the ack skips WAIT entirely.
          if (CoreAck && CoreDone) begin
            CoreReq   <= 1'b0;
            verdict_q <= CoreIsPrime;
            state     <= S_RECORD;
`ifdef PRIME_SWEEP_TIMEOUT_EN
          end else if (tmo_hit) begin
            CoreReq <= 1'b0;
            Error   <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state   <= S_DONE;
`endif
          end else if (CoreAck) begin
            CoreReq <= 1'b0;
            state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (CoreDone) begin
            verdict_q <= CoreIsPrime;
            state     <= S_RECORD;
`ifdef PRIME_SWEEP_TIMEOUT_EN
          end else if (tmo_hit) begin
            Error <= 1'b1;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
`endif
          end
        end

        S_RECORD: begin
          NumberChecked <= cand_q;
          Prime         <= verdict_q;
          ResultValid   <= 1'b1;
          if (verdict_q && (NumberofPrimesFound != {CNT_W{1'b1}})) begin
            NumberofPrimesFound <= NumberofPrimesFound + CNT_W'(1);
          end
          // Equality stop means a max of all-ones never lets the candidate wrap.
          if (cand_q == max_q) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cand_q  <= cand_q + NUM_W'(1);
            CoreNum <= cand_q + NUM_W'(1);
            CoreReq <= 1'b1;
            state   <= S_ISSUE;
`ifdef PRIME_SWEEP_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_sweep_ctrl.sv
// Scoreboard bench for prime_sweep_ctrl: a behavioural core answers requests with random delays.
// Expected records come from trial-division primality and are queued at Start; a monitor pops them on ResultValid.
// Runs a full 2..1000 sweep, small and degenerate bounds, a slow ack, ignored Starts, a mid-sweep reset and, with the macro, the timeout.
module tb_prime_sweep_ctrl;
  localparam int NUM_W = 10;
  localparam int CNT_W = 8;
  localparam int TMO   = 16;

  logic             SysClk = 1'b0;
  logic             Reset  = 1'b0;
  logic             Start  = 1'b0;
  logic [NUM_W-1:0] NumMax = '0;
  logic             CoreReq;
  logic [NUM_W-1:0] CoreNum;
  logic             CoreAck = 1'b0;
  logic             CoreDone = 1'b0;
  logic             CoreIsPrime = 1'b0;
  logic             Prime;
  logic [NUM_W-1:0] NumberChecked;
  logic [CNT_W-1:0] NumberofPrimesFound;
  logic             ResultValid;
  logic             Busy;
  logic             Done;
  logic             Error;

  prime_sweep_ctrl #(.NUM_W(NUM_W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .SysClk(SysClk), .Reset(Reset), .Start(Start), .NumMax(NumMax),
    .CoreReq(CoreReq), .CoreNum(CoreNum), .CoreAck(CoreAck), .CoreDone(CoreDone),
    .CoreIsPrime(CoreIsPrime), .Prime(Prime), .NumberChecked(NumberChecked),
    .NumberofPrimesFound(NumberofPrimesFound), .ResultValid(ResultValid),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 SysClk = ~SysClk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int num;
    bit prime;
    int cnt;
    bit last;
  } exp_t;
  exp_t sb[$];

  // Core behaviour knobs
  int ack_max  = 0;
  int done_min = 2;
  int done_max = 2;
  bit slow7    = 1'b0;
  bit spur_en  = 1'b0;
  int hang_at  = 0;

  function automatic bit is_prime(int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Behavioural core plus output monitor, both acting on the falling edge
  initial begin : core_and_monitor
    int               ack_left;
    int               done_left;
    int               dl;
    bit               in_flight;
    bit               req_seen;
    bit               prev_req;
    bit               prev_ack;
    logic [NUM_W-1:0] held;
    logic [NUM_W-1:0] prev_num;
    exp_t             e;
    in_flight = 0; req_seen = 0; prev_req = 0; prev_ack = 0;
    ack_left = 0; done_left = 0; held = '0; prev_num = '0;
    forever begin
      @(negedge SysClk);
      if (!Reset) begin
        in_flight = 0; req_seen = 0; prev_req = 0; prev_ack = 0;
        CoreAck = 1'b0; CoreDone = 1'b0;
        continue;
      end
      // Monitor
      check("busy_done_exclusive", 32'(Busy && Done), 32'(0));
      if (prev_req && !prev_ack && CoreReq) check("corenum_stable", 32'(CoreNum), 32'(prev_num));
      if (ResultValid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got record for %0d, required none", NumberChecked);
        end else begin
          e = sb.pop_front();
          check("number_checked", 32'(NumberChecked), e.num);
          check("prime_verdict", 32'(Prime), 32'(e.prime));
          check("prime_count", 32'(NumberofPrimesFound), e.cnt);
          if (e.last) check("done_with_last", 32'(Done), 32'(1));
          else        check("busy_mid_sweep", 32'(Busy), 32'(1));
        end
      end
      prev_req = CoreReq;
      prev_num = CoreNum;
      // Core driver
      CoreAck = 1'b0; CoreDone = 1'b0; CoreIsPrime = 1'($urandom);
      if (in_flight) begin
        if (done_left == 0) begin
          CoreDone = 1'b1; CoreIsPrime = is_prime(int'(held)); in_flight = 0;
        end else begin
          done_left--;
        end
      end else if (CoreReq) begin
        if (!req_seen) begin
          req_seen = 1;
          ack_left = (slow7 && CoreNum == NUM_W'(7)) ? 5 : $urandom_range(ack_max, 0);
        end
        if (ack_left == 0) begin
          CoreAck = 1'b1; held = CoreNum; req_seen = 0;
          if (hang_at == 0 || int'(CoreNum) != hang_at) begin
            dl = $urandom_range(done_max, done_min);
            if (dl == 0) begin
              CoreDone = 1'b1; CoreIsPrime = is_prime(int'(held));
            end else begin
              in_flight = 1; done_left = dl - 1;
            end
          end
        end else begin
          ack_left--;
        end
      end else if (spur_en && ($urandom % 8 == 0)) begin
        CoreAck = 1'b1; CoreDone = 1'b1; CoreIsPrime = 1'b1;
      end
      prev_ack = CoreAck;
    end
  end

  // Queue the expected records for one sweep and return the final count
  function automatic int push_exp(input int mx, input int hang);
    int c = 0;
    for (int n = 2; n <= mx; n++) begin
      if (hang != 0 && n >= hang) break;
      if (is_prime(n)) c = (c < 255) ? c + 1 : c;
      sb.push_back('{num: n, prime: is_prime(n), cnt: c, last: (n == mx)});
    end
    return c;
  endfunction

  task automatic run_sweep(input int mx, input bit noise, input int hang);
    int exp_cnt;
    int cyc;
    int budget;
    exp_cnt = push_exp(mx, hang);
    budget  = (mx + 2) * 30 + 4 * TMO + 50;
    @(negedge SysClk);
    Start = 1'b1; NumMax = NUM_W'(mx);
    @(negedge SysClk);
    Start = 1'b0; NumMax = NUM_W'($urandom);
    check("start_corereq", 32'(CoreReq), 32'(mx >= 2));
    check("start_busy", 32'(Busy), 32'(mx >= 2));
    check("start_done", 32'(Done), 32'(mx < 2));
    check("start_count_clear", 32'(NumberofPrimesFound), 32'(0));
    check("start_checked_clear", 32'(NumberChecked), 32'(0));
    check("start_error_clear", 32'(Error), 32'(0));
    cyc = 0;
    while (!Done && cyc < budget) begin
      Start = noise && Busy && ($urandom % 4 == 0);
      if (Start) NumMax = NUM_W'($urandom);
      @(negedge SysClk);
      cyc++;
    end
    Start = 1'b0;
    #1;
    check("sweep_done", 32'(Done), 32'(1));
    check("sweep_busy_low", 32'(Busy), 32'(0));
    check("final_count", 32'(NumberofPrimesFound), exp_cnt);
    check("records_outstanding", 32'(sb.size()), 32'(0));
    check("error_flag", 32'(Error), 32'(hang != 0));
    sb.delete();
  endtask

  initial begin : stimulus
    int cyc;
    #1;
    check("rst_corereq", 32'(CoreReq), 32'(0));
    check("rst_corenum", 32'(CoreNum), 32'(0));
    check("rst_checked", 32'(NumberChecked), 32'(0));
    check("rst_count", 32'(NumberofPrimesFound), 32'(0));
    check("rst_flags", 32'({Prime, ResultValid, Busy, Done, Error}), 32'(0));
    repeat (2) @(negedge SysClk);
    #2 Reset = 1'b1;

    // Full sweep, ack same cycle, done two cycles later
    run_sweep(1000, 1'b0, 0);
    run_sweep(10, 1'b0, 0);
    run_sweep(1, 1'b0, 0);
    run_sweep(0, 1'b0, 0);

    // Slow ack on 7, random core timing, ignored Starts and spurious pulses
    ack_max = 3; done_min = 0; done_max = 6; slow7 = 1'b1; spur_en = 1'b1;
    run_sweep(60, 1'b1, 0);
    for (int i = 0; i < 8; i++) run_sweep($urandom_range(200, 0), 1'b1, 0);
    run_sweep(2, 1'b0, 0);

    // Asynchronous reset while candidate 37 is being requested
    void'(push_exp(100, 0));
    @(negedge SysClk);
    Start = 1'b1; NumMax = NUM_W'(100);
    @(negedge SysClk);
    Start = 1'b0;
    cyc = 0;
    while (!(CoreReq && CoreNum == NUM_W'(37)) && cyc < 4000) begin
      @(negedge SysClk);
      cyc++;
    end
    check("reached_37", 32'(CoreNum), 32'(37));
    #2 Reset = 1'b0;
    #1;
    check("midrst_corereq", 32'(CoreReq), 32'(0));
    check("midrst_corenum", 32'(CoreNum), 32'(0));
    check("midrst_checked", 32'(NumberChecked), 32'(0));
    check("midrst_count", 32'(NumberofPrimesFound), 32'(0));
    check("midrst_flags", 32'({Prime, ResultValid, Busy, Done, Error}), 32'(0));
    sb.delete();
    @(negedge SysClk);
    #2 Reset = 1'b1;
    run_sweep(50, 1'b0, 0);
    check("count_to_50", 32'(NumberofPrimesFound), 32'(15));

`ifdef PRIME_SWEEP_TIMEOUT_EN
    // Core never answers for 11: timeout after TMO cycles, then a clean restart
    ack_max = 0; done_min = 1; done_max = 2; slow7 = 1'b0; spur_en = 1'b0; hang_at = 11;
    run_sweep(20, 1'b0, 11);
    check("timeout_count", 32'(NumberofPrimesFound), 32'(4));
    check("timeout_checked", 32'(NumberChecked), 32'(10));
    hang_at = 0;
    run_sweep(5, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
